// File: rtl/score_pkg.sv
// Shared types and defaults for the score digit sequencer.
package score_pkg;

  localparam int NUM_DIGITS  = 4;
  localparam int DIGIT_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_PENDING = 2'd2
  } seq_state_t;

  typedef logic [3:0] bcd_digit_t;

  // 10**n as a constant; used for the saturation threshold.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// A start pulse loads the operand; done is high during the last shift cycle and
// the result on bcd is final from the following cycle until the next start.
// Scores of 10**NUM_DIGITS or more read back as all nines.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int SCORE_W    = 14,
  parameter int NUM_DIGITS = score_pkg::NUM_DIGITS
) (
  input  logic                    pixel_clk_in,
  input  logic                    rst_n_in,
  input  logic                    start,
  input  logic [SCORE_W-1:0]      bin,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam longint unsigned LIMIT = pow10(NUM_DIGITS);

  logic [SCORE_W-1:0]      shift_q;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [4*NUM_DIGITS-1:0] bcd_adj;
  logic [CNT_W-1:0]        cnt_q;
  logic                    busy_q;
  logic                    sat_q;

  // Add 3 to every nibble that is 5 or more before the shift.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Load on start, then shift one operand bit into the BCD field per cycle.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n_in) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else if (start) begin
      shift_q <= bin;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      sat_q   <= (64'(bin) >= LIMIT);
    end else if (busy_q) begin
      bcd_q   <= {bcd_adj[4*NUM_DIGITS-2:0], shift_q[SCORE_W-1]};
      shift_q <= {shift_q[SCORE_W-2:0], 1'b0};
      cnt_q   <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(SCORE_W - 1)) busy_q <= 1'b0;
    end
  end

  assign done = busy_q && (cnt_q == CNT_W'(SCORE_W - 1));
  assign bcd  = sat_q ? {NUM_DIGITS{4'd9}} : bcd_q;

endmodule

// File: rtl/score_digit_sequencer.sv
// Score digit sequencer: converts a binary score to BCD, swaps it into the
// display register only at frame start, and tells the glyph renderer which
// digit and cell origin is under the raster, one cycle after hcount/vcount.
// Optional macro SCORE_LZ_BLANK_EN blanks leading zeros (never the last digit).
module score_digit_sequencer
  import score_pkg::*;
#(
  parameter int NUM_DIGITS  = score_pkg::NUM_DIGITS,
  parameter int DIGIT_WIDTH = score_pkg::DIGIT_WIDTH,
  parameter int SCORE_W     = 14
) (
  input  logic               pixel_clk_in,
  input  logic               rst_n_in,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_valid_in,
  output logic               score_ready_out,
  input  logic [10:0]        x_in,
  input  logic [9:0]         y_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  output bcd_digit_t         number_out,
  output logic [10:0]        digit_x_out,
  output logic [9:0]         digit_y_out,
  output logic               blank_out
);

  localparam int IDX_W = $clog2(NUM_DIGITS + 1);
  localparam int COL_W = (DIGIT_WIDTH > 1) ? $clog2(DIGIT_WIDTH) : 1;

  seq_state_t              state_q;
  logic [4*NUM_DIGITS-1:0] disp_q;
  logic [4*NUM_DIGITS-1:0] conv_bcd;
  logic                    conv_start;
  logic                    conv_done;
  logic                    frame_start;

  logic [COL_W-1:0] col_q, cur_col;
  logic [IDX_W-1:0] idx_q, cur_idx;
  logic             row_hit;
  logic             cell_valid;
  bcd_digit_t       cur_digit;
  logic             lz_blank;

  assign conv_start  = (state_q == ST_IDLE) && score_valid_in && score_ready_out;
  assign frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);

  bin2bcd_seq #(
    .SCORE_W    (SCORE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .pixel_clk_in (pixel_clk_in),
    .rst_n_in     (rst_n_in),
    .start        (conv_start),
    .bin          (score_in),
    .done         (conv_done),
    .bcd          (conv_bcd)
  );

  // Accept -> convert -> wait for frame start -> swap display -> idle.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= ST_IDLE;
      score_ready_out <= 1'b0;
      // NOTE: the display register is explicitly reset so a blank frame shows 0000, not X.
      disp_q          <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (conv_start) begin
            state_q         <= ST_CONVERT;
            score_ready_out <= 1'b0;
          end else begin
            score_ready_out <= 1'b1;
          end
        end
        ST_CONVERT: begin
          score_ready_out <= 1'b0;
          if (conv_done) state_q <= ST_PENDING;
        end
        ST_PENDING: begin
          if (frame_start) begin
            disp_q          <= conv_bcd;
            state_q         <= ST_IDLE;
            score_ready_out <= 1'b1;
          end
        end
        default: begin
          state_q         <= ST_IDLE;
          score_ready_out <= 1'b0;
        end
      endcase
    end
  end

  // Cell position for the current pixel: restarts at the left edge of digit 0.
  always_comb begin
    if (hcount_in == x_in) begin
      cur_col = '0;
      cur_idx = '0;
    end else begin
      cur_col = col_q;
      cur_idx = idx_q;
    end
  end

  // Column/index counters; the index parks at NUM_DIGITS past the last cell.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      col_q <= '0;
      idx_q <= IDX_W'(NUM_DIGITS);
    end else if (cur_col == COL_W'(DIGIT_WIDTH - 1)) begin
      col_q <= '0;
      idx_q <= (cur_idx < IDX_W'(NUM_DIGITS)) ? cur_idx + 1'b1 : cur_idx;
    end else begin
      col_q <= cur_col + 1'b1;
      idx_q <= cur_idx;
    end
  end

  assign row_hit    = ({1'b0, vcount_in} >= {1'b0, y_in}) &&
                      ({1'b0, vcount_in} < ({1'b0, y_in} + 11'(DIGIT_WIDTH)));
  assign cell_valid = (cur_idx < IDX_W'(NUM_DIGITS)) && row_hit;

  // Pick the digit for the active index; index 0 is the most significant.
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cur_idx == IDX_W'(i)) cur_digit = disp_q[4*(NUM_DIGITS-1-i) +: 4];
    end
  end

`ifdef SCORE_LZ_BLANK_EN
  // Blank the active digit when it and every more significant digit are zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      all_zero = all_zero && (disp_q[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      if (cur_idx == IDX_W'(i)) lz_blank = all_zero;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Registered display outputs, one cycle behind hcount/vcount.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      number_out  <= '0;
      digit_x_out <= '0;
      digit_y_out <= '0;
      blank_out   <= 1'b1;
    end else begin
      digit_x_out <= x_in + 11'(int'(cur_idx) * DIGIT_WIDTH);
      digit_y_out <= y_in;
      if (cell_valid && !lz_blank) begin
        number_out <= cur_digit;
        blank_out  <= 1'b0;
      end else begin
        number_out <= '0;
        blank_out  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_score_digit_sequencer.sv
// Self-checking bench for score_digit_sequencer: directed steps, raster
// expectations queued when hcount/vcount are driven and popped one cycle later.
module tb_score_digit_sequencer;

  localparam int NUM_DIGITS = 4;
  localparam int DW         = 24;
  localparam int SCORE_W    = 14;
  localparam logic [10:0] X0 = 11'd100;
  localparam logic [9:0]  Y0 = 10'd190;

  logic               pixel_clk_in;
  logic               rst_n_in;
  logic [SCORE_W-1:0] score_in;
  logic               score_valid_in;
  logic               score_ready_out;
  logic [10:0]        x_in;
  logic [9:0]         y_in;
  logic [10:0]        hcount_in;
  logic [9:0]         vcount_in;
  logic [3:0]         number_out;
  logic [10:0]        digit_x_out;
  logic [9:0]         digit_y_out;
  logic               blank_out;

  score_digit_sequencer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .DIGIT_WIDTH (DW),
    .SCORE_W     (SCORE_W)
  ) dut (
    .pixel_clk_in    (pixel_clk_in),
    .rst_n_in        (rst_n_in),
    .score_in        (score_in),
    .score_valid_in  (score_valid_in),
    .score_ready_out (score_ready_out),
    .x_in            (x_in),
    .y_in            (y_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .number_out      (number_out),
    .digit_x_out     (digit_x_out),
    .digit_y_out     (digit_y_out),
    .blank_out       (blank_out)
  );

  initial pixel_clk_in = 1'b0;
  always #5 pixel_clk_in = ~pixel_clk_in;

  typedef struct {
    logic [3:0]  num;
    logic [10:0] dx;
    logic [9:0]  dy;
    logic        blank;
    bit          check_pos;
  } exp_t;

  exp_t sb[$];
  int   shown[NUM_DIGITS];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk_in);
    #1;
  endtask

  task automatic park();
    hcount_in = 11'd600;
    vcount_in = 10'd500;
  endtask

  // Expected displayed digits for a score, saturated to all nines.
  task automatic set_shown(input int s);
    int v, p;
    v = (s >= 10000) ? 9999 : s;
    p = 1000;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      shown[i] = (v / p) % 10;
      p = p / 10;
    end
  endtask

  // Expected registered outputs for a raster position, assuming a left-to-right sweep.
  function automatic exp_t model(input int h, input int v);
    exp_t e;
    int   idx;
    bit   valid;
    bit   lz;
    idx = (h < int'(X0)) ? NUM_DIGITS : (h - int'(X0)) / DW;
    if (idx > NUM_DIGITS) idx = NUM_DIGITS;
    valid = (idx < NUM_DIGITS) && (v >= int'(Y0)) && (v < int'(Y0) + DW);
    lz = 1'b0;
`ifdef SCORE_LZ_BLANK_EN
    if (valid && idx < NUM_DIGITS - 1) begin
      lz = 1'b1;
      for (int i = 0; i <= idx; i++) if (shown[i] != 0) lz = 1'b0;
    end
`endif
    e.blank     = !(valid && !lz);
    e.num       = e.blank ? 4'd0 : 4'(shown[idx]);
    e.dx        = 11'(int'(X0) + idx * DW);
    e.dy        = Y0;
    e.check_pos = valid;
    return e;
  endfunction

  // Sweep one raster line across all cells and compare every cycle.
  task automatic scan(input int v, input string tag);
    exp_t e;
    for (int h = int'(X0) - 2; h <= int'(X0) + NUM_DIGITS * DW + 1; h++) begin
      hcount_in = 11'(h);
      vcount_in = 10'(v);
      sb.push_back(model(h, v));
      tick();
      e = sb.pop_front();
      check({tag, "_blank"}, blank_out, e.blank);
      check({tag, "_number"}, number_out, e.num);
      if (e.check_pos) begin
        check({tag, "_digit_x"}, digit_x_out, e.dx);
        check({tag, "_digit_y"}, digit_y_out, e.dy);
      end
    end
    park();
  endtask

  // Offer a score and complete the handshake; ready must drop right after.
  task automatic send(input int s);
    int n;
    n = 0;
    while (!score_ready_out && n < 100) begin
      tick();
      n++;
    end
    check("ready_before_send", score_ready_out, 1'b1);
    score_in       = SCORE_W'(s);
    score_valid_in = 1'b1;
    tick();
    score_valid_in = 1'b0;
    check("ready_low_after_accept", score_ready_out, 1'b0);
  endtask

  // Convert with the raster held at frame start; ready returns after
  // SCORE_W convert cycles plus the frame-start cycle in PENDING.
  task automatic load(input int s, input string tag);
    int n;
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    send(s);
    n = 0;
    while (!score_ready_out && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_busy_cycles"}, n, SCORE_W + 1);
    set_shown(s);
    park();
    tick();
  endtask

  initial begin
    rst_n_in       = 1'b0;
    score_in       = '0;
    score_valid_in = 1'b0;
    x_in           = X0;
    y_in           = Y0;
    park();
    set_shown(0);

    // Reset values.
    repeat (3) tick();
    check("rst_number", number_out, 4'd0);
    check("rst_digit_x", digit_x_out, 11'd0);
    check("rst_digit_y", digit_y_out, 10'd0);
    check("rst_blank", blank_out, 1'b1);
    check("rst_ready", score_ready_out, 1'b0);
    rst_n_in = 1'b1;
    check("ready_before_first_edge", score_ready_out, 1'b0);
    tick();
    check("ready_first_cycle", score_ready_out, 1'b1);
    scan(Y0, "init");

    // 1234 appears in four cells at X0 + k*24.
    load(1234, "s1234");
    scan(Y0 + 5, "s1234");

    // Saturation, then row boundaries: last valid row, first row below, row above.
    load(16383, "s16383");
    scan(Y0 + 23, "s9999_lastrow");
    scan(Y0 + 24, "s9999_below");
    scan(Y0 - 1, "s9999_above");

    // Score 5 accepted mid-frame: old digits kept until frame start.
    hcount_in = 11'd300;
    vcount_in = 10'd200;
    send(5);
    repeat (30) tick();
    check("pending_ready_low", score_ready_out, 1'b0);
    score_in       = SCORE_W'(42);
    score_valid_in = 1'b1;
    repeat (3) tick();
    check("pending_ignores_valid", score_ready_out, 1'b0);
    score_valid_in = 1'b0;
    scan(200, "midframe_old");
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    tick();
    check("frame_start_ready", score_ready_out, 1'b1);
    set_shown(5);
    park();
    tick();
    scan(200, "midframe_new");

    // Single digit: leading zeros drawn or blanked depending on the build.
    load(7, "s7");
    scan(Y0, "s7");

    // Reset during CONVERT: outputs clear at once, partial result discarded.
    scan(Y0, "pre_reset");
    hcount_in = X0 + 11'd30;
    vcount_in = Y0 + 10'd3;
    send(1234);
    repeat (5) tick();
    #2;
    rst_n_in = 1'b0;
    #1;
    check("async_rst_number", number_out, 4'd0);
    check("async_rst_digit_x", digit_x_out, 11'd0);
    check("async_rst_digit_y", digit_y_out, 10'd0);
    check("async_rst_blank", blank_out, 1'b1);
    check("async_rst_ready", score_ready_out, 1'b0);
    @(posedge pixel_clk_in);
    @(posedge pixel_clk_in);
    #1;
    park();
    rst_n_in = 1'b1;
    tick();
    check("ready_after_rerelease", score_ready_out, 1'b1);
    set_shown(0);
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    repeat (20) tick();
    park();
    tick();
    scan(Y0 + 10, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_digit_sequencer.md
SCORE_DIGIT_SEQUENCER -- requirements
Module: score_digit_sequencer

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of decimal digits shown.
REQ-002 SHALL have parameter DIGIT_WIDTH, default 24, glyph pitch in pixels.
REQ-003 SHALL have parameter SCORE_W, default 14, binary score width.
REQ-004 SHALL have port pixel_clk_in, input, 1, the only clock.
REQ-005 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port score_in, input, SCORE_W, binary score to display.
REQ-007 SHALL have port score_valid_in, input, 1, score_in offered.
REQ-008 SHALL have port score_ready_out, output, 1, converter idle and accepts score.
REQ-009 SHALL have ports x_in (11) and y_in (10), inputs, top-left of the most significant digit.
REQ-010 SHALL have ports hcount_in (11) and vcount_in (10), inputs, raster position.
REQ-011 SHALL have port number_out, output, 4, BCD digit (0-9) for the glyph ROM.
REQ-012 SHALL have ports digit_x_out (11) and digit_y_out (10), outputs, origin of the active digit cell.
REQ-013 SHALL have port blank_out, output, 1, active digit not drawn.

Function
REQ-014 SHALL accept a score on the cycle where score_valid_in and score_ready_out are both high; score_ready_out SHALL be low from the next cycle until conversion ends.
REQ-015 SHALL run FSM IDLE -> CONVERT -> PENDING -> IDLE; CONVERT SHALL last exactly SCORE_W cycles (double-dabble: add 3 to each nibble >=5, then shift).
REQ-016 SHALL, if score_in >= 10^NUM_DIGITS, saturate the result to all nines (e.g. 16383 -> 9999).
REQ-017 SHALL hold the result in PENDING and copy it to the display register only on the cycle hcount_in==0 and vcount_in==0 (frame start), then return to IDLE; no mid-frame tearing.
REQ-018 SHALL track the active cell with a column counter and digit index: reset both on the cycle hcount_in==x_in; increment column; on column==DIGIT_WIDTH-1 wrap it to 0 and increment index; the cell is valid while index < NUM_DIGITS and y_in <= vcount_in < y_in+DIGIT_WIDTH.
REQ-019 SHALL register all display outputs; latency from hcount_in/vcount_in to number_out, digit_x_out, digit_y_out and blank_out SHALL be exactly 1 cycle.
REQ-020 SHALL drive digit_x_out = x_in + index*DIGIT_WIDTH (mod 2^11) and digit_y_out = y_in; index 0 SHALL be the most significant digit.
REQ-021 SHALL drive blank_out high and number_out 0 outside any valid cell.
REQ-022 SHALL ignore score_valid_in while not in IDLE; a new score offered during PENDING SHALL wait.

Reset
REQ-023 SHALL, on rst_n_in low, asynchronously enter IDLE and clear the display register to 0, number_out to 0, digit_x_out and digit_y_out to 0, blank_out to 1 and score_ready_out to 0; score_ready_out SHALL rise the first cycle after reset release.
REQ-024 SHALL, on reset during CONVERT or PENDING, discard the partial result.

Configuration
REQ-025 SHALL, with SCORE_LZ_BLANK_EN defined, force blank_out high for leading-zero digits, excluding the least significant digit; without the macro, zeros SHALL be drawn normally.

Structure
REQ-026 SHALL take NUM_DIGITS, DIGIT_WIDTH, the FSM state enum and the BCD digit typedef from package score_pkg.
REQ-027 SHALL implement conversion in sub-module bin2bcd_seq, with a start/done handshake.

Verification
REQ-028 SHALL test: reset, then score 1234 accepted, frame start -> after 14 busy cycles and a frame start, cells show 1,2,3,4 at x_in, x_in+24, x_in+48, x_in+72.
REQ-029 SHALL test: score 16383 -> display 9999.
REQ-030 SHALL test: score 7 with SCORE_LZ_BLANK_EN -> blank_out high for cells 0-2 and low with number_out 7 for cell 3; without the macro, 0,0,0,7 drawn.
REQ-031 SHALL test: score 5 accepted mid-frame at vcount 200 -> old digits kept until the next hcount 0/vcount 0, then 0005.
REQ-032 SHALL test: rst_n_in pulsed low during CONVERT -> outputs at reset values immediately, and 0000 shown after release.
REQ-033 SHALL test: hcount_in=x_in+23 vs x_in+24 -> one cycle later, index 0 and then index 1; vcount_in=y_in+24 -> blank_out high.
